// File: rtl/core.sv
// Shared core-wide widths and register typedefs.
package core;

  localparam int REG_WIDTH     = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef logic [REG_WIDTH-1:0]     RegVal;
  typedef logic [RF_ADDR_WIDTH-1:0] RegAddr;

endpackage

// File: rtl/tachyon_rf_read_port.sv
// One combinational register-file read port: address decode plus write-first bypass.
module tachyon_rf_read_port #(
  parameter int REG_WIDTH     = core::REG_WIDTH,
  parameter int RF_ADDR_WIDTH = core::RF_ADDR_WIDTH,
  parameter int DEPTH         = 2**RF_ADDR_WIDTH
) (
  input  logic                     rst,
  input  logic [RF_ADDR_WIDTH-1:0] rd_addr,
  input  logic [REG_WIDTH-1:0]     regs [DEPTH],
  input  logic                     wr_enable,
  input  logic [RF_ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0]     wr_val,
  output logic [REG_WIDTH-1:0]     rd_val
);

  always_comb begin
    rd_val = '0;
    // Reset overrides everything, including a pending bypass.
    if (rst) begin
      rd_val = '0;
    end else if ($isunknown(rd_addr)) begin
      rd_val = 'x;
    end else if (wr_enable && (rd_addr == wr_addr)) begin
      rd_val = wr_val;
    end else begin
      rd_val = regs[rd_addr];
    end
  end

endmodule

// File: rtl/tachyon_reg_file.sv
// Multi-read, single-write register file with write-first bypass and async clear.
module tachyon_reg_file #(
  parameter int NUM_RD_PORTS  = 3,
  parameter int REG_WIDTH     = core::REG_WIDTH,
  parameter int RF_ADDR_WIDTH = core::RF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RF_ADDR_WIDTH-1:0] rd_addr [NUM_RD_PORTS],
  output logic [REG_WIDTH-1:0]     rd_val  [NUM_RD_PORTS],
  input  logic                     wr_enable,
  input  logic [RF_ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0]     wr_val
);

  localparam int DEPTH = 2**RF_ADDR_WIDTH;

  logic [REG_WIDTH-1:0] regs_q [DEPTH];
  logic [REG_WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (wr_enable) begin
      regs_d[wr_addr] = wr_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_enable) begin
        assert (!$isunknown(wr_addr));
      end
      regs_q <= regs_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_port
    tachyon_rf_read_port #(
      .REG_WIDTH     (REG_WIDTH),
      .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
      .DEPTH         (DEPTH)
    ) u_rd_port (
      .rst       (rst),
      .rd_addr   (rd_addr[gi]),
      .regs      (regs_q),
      .wr_enable (wr_enable),
      .wr_addr   (wr_addr),
      .wr_val    (wr_val),
      .rd_val    (rd_val[gi])
    );
  end

endmodule

// File: tb/tb_tachyon_reg_file.sv
// Directed and randomized checks of tachyon_reg_file against a simple array model.
module tb_tachyon_reg_file;

  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr [NP];
  logic [31:0] rd_val  [NP];
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_val;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [32];

  tachyon_reg_file #(
    .NUM_RD_PORTS  (NP),
    .REG_WIDTH     (32),
    .RF_ADDR_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_val    (rd_val),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .wr_val    (wr_val)
  );

  always #5 clk = ~clk;

  // Reference: what a read of addr should return right now.
  function automatic logic [31:0] model_rd(input logic [4:0] addr);
    if (rst) return 32'd0;
    if (wr_enable && addr == wr_addr) return wr_val;
    return ref_mem[addr];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
  endtask

  // Advance one rising edge, mirroring the committed write in the model.
  task automatic cycle();
    @(posedge clk);
    if (!rst && wr_enable) ref_mem[wr_addr] = wr_val;
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk_val(input string tag, input int p, input logic [31:0] exp);
    #1;
    vectors++;
    assert (rd_val[p] === exp) else begin
      miscompares++;
      $error("FAIL %s port%0d addr=%0d got=%h exp=%h", tag, p, rd_addr[p], rd_val[p], exp);
    end
  endtask

  task automatic chk_model(input string tag, input int p);
    chk_val(tag, p, model_rd(rd_addr[p]));
  endtask

  initial begin
    rst = 1'b1;
    wr_enable = 1'b0;
    wr_addr = '0;
    wr_val = '0;
    for (int i = 0; i < NP; i++) rd_addr[i] = '0;
    clear_model();
    repeat (2) cycle();

    // Writes during reset are blocked and reads return 0.
    settle();
    wr_enable = 1'b1; wr_addr = 5'd3; wr_val = 32'd5; rd_addr[0] = 5'd3;
    chk_val("rst_bypass_blocked", 0, 32'd0);
    cycle();
    settle();
    wr_enable = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      chk_val("rst_read_zero", 0, 32'd0);
    end

    // Release reset; the write at reg[3] stays lost, the next edge writes.
    rst = 1'b0;
    rd_addr[0] = 5'd3;
    chk_val("reg3_after_rst", 0, 32'd0);
    wr_enable = 1'b1; wr_addr = 5'd4; wr_val = 32'h44;
    cycle();
    settle();
    wr_enable = 1'b0; rd_addr[0] = 5'd4;
    chk_val("first_write_after_rst", 0, 32'h44);

    // Bypass then persistence.
    wr_enable = 1'b1; wr_addr = 5'd7; wr_val = 32'd123; rd_addr[0] = 5'd7;
    chk_val("bypass_same_cycle", 0, 32'd123);
    cycle();
    settle();
    wr_enable = 1'b0;
    chk_val("bypass_stored", 0, 32'd123);

    // Streaming lockstep write/read, wrapping 31 -> 0.
    for (int k = 0; k < 30; k++) begin
      wr_enable = 1'b1;
      wr_addr = 5'((7 + k) % 32);
      wr_val = 32'(123 + k);
      rd_addr[0] = wr_addr;
      chk_val("stream", 0, 32'(123 + k));
      cycle();
      settle();
    end
    wr_enable = 1'b0;

    // Multi-port reads.
    wr_enable = 1'b1;
    wr_addr = 5'd1; wr_val = 32'hA; cycle(); settle();
    wr_addr = 5'd2; wr_val = 32'hB; cycle(); settle();
    wr_addr = 5'd3; wr_val = 32'hC; cycle(); settle();
    wr_enable = 1'b0;
    rd_addr[0] = 5'd1; rd_addr[1] = 5'd2; rd_addr[2] = 5'd3;
    chk_val("multi_p0", 0, 32'hA);
    chk_val("multi_p1", 1, 32'hB);
    chk_val("multi_p2", 2, 32'hC);
    rd_addr[0] = 5'd2; rd_addr[1] = 5'd2; rd_addr[2] = 5'd2;
    chk_val("same_p0", 0, 32'hB);
    chk_val("same_p1", 1, 32'hB);
    chk_val("same_p2", 2, 32'hB);

    // Write disable holds storage.
    wr_enable = 1'b1; wr_addr = 5'd5; wr_val = 32'h55;
    cycle(); settle();
    wr_enable = 1'b0; wr_val = 32'hFF; rd_addr[1] = 5'd5;
    for (int k = 0; k < 3; k++) begin
      chk_val("wr_disable", 1, 32'h55);
      cycle(); settle();
    end
    chk_val("wr_disable_end", 1, 32'h55);

    // Async reset between edges clears immediately.
    wr_enable = 1'b1; wr_addr = 5'd9; wr_val = 32'h99;
    cycle(); settle();
    wr_enable = 1'b0; rd_addr[2] = 5'd9;
    chk_val("reg9_written", 2, 32'h99);
    #1;
    rst = 1'b1;
    clear_model();
    chk_val("async_rst_clear", 2, 32'd0);
    #1;
    rst = 1'b0;
    chk_val("async_rst_held", 2, 32'd0);
    settle();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      wr_enable = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_val = $urandom;
      for (int p = 0; p < NP; p++) begin
        rd_addr[p] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      end
      for (int p = 0; p < NP; p++) chk_model("random", p);
      cycle();
      settle();
    end

    // Sweep all addresses after random writes.
    wr_enable = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      chk_model("final_sweep", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
